// File: rtl/sram_pkg.sv
// Shared types and default geometry/timing for the SRAM read/write controller.
package sram_pkg;

  localparam int DEF_ROWS     = 8;
  localparam int DEF_COLS     = 8;
  localparam int DEF_WR_PULSE = 2;
  localparam int DEF_PRE_CYC  = 1;
  localparam int DEF_ACC_CYC  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_PULSE = 3'd2,
    W_HOLD  = 3'd3,
    R_PRE   = 3'd4,
    R_ACC   = 3'd5,
    RESP    = 3'd6
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_sense_latch.sv
// Per-column differential sense: resolves bit-line pairs into data bits,
// flags columns with equal levels, and holds the result until reloaded.
module sram_sense_latch #(
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            clear,
  input  logic            force_err,
  input  logic [COLS-1:0] bl,
  input  logic [COLS-1:0] blb,
  output logic [COLS-1:0] data,
  output logic            err
);

  logic [COLS-1:0] bit_val;
  logic [COLS-1:0] bit_bad;

  // Only a clean bl=1/blb=0 pair reads as 1; any equal pair reads as 0 and is bad.
  always_comb begin
    bit_val = bl & ~blb;
    bit_bad = ~(bl ^ blb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      err  <= 1'b0;
    end else if (capture) begin
      data <= bit_val;
      err  <= |bit_bad;
    end else if (clear) begin
      data <= '0;
      err  <= force_err;
    end
  end

endmodule

// File: rtl/sram_rw_ctrl.sv
// SRAM word-line / bit-line sequencer: one request at a time, timed write
// and read phases, registered array-facing outputs and a one-cycle response.
module sram_rw_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int ACC_CYC  = DEF_ACC_CYC,
  localparam int AW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; req_ready is high only while idle, and the
  // requester must hold we/addr/wdata stable while req_valid is high.
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic [ROWS-1:0] row_wr,
  output logic [ROWS-1:0] row_rd,
  output logic [COLS-1:0] bl_wr,
  output logic [COLS-1:0] blb_wr,
  output logic            pre_rd,
  input  logic [COLS-1:0] bl_rd,
  input  logic [COLS-1:0] blb_rd,
  output logic            rsp_valid,
  output logic            rsp_we,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output state_t          state
);

  localparam int MAXC = max3(WR_PULSE, PRE_CYC, ACC_CYC);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [COLS-1:0] wdata_q;

  logic            accept;
  logic            addr_bad;
  logic            we_n;
  logic [AW-1:0]   addr_n;
  logic [COLS-1:0] wdata_n;
  logic [ROWS-1:0] row_dec;
  logic            sense_capture;
  logic            sense_clear;
  logic            sense_force_err;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_bad  = ({1'b0, req_addr} >= (AW+1)'(ROWS));

  // Values that will be latched at this edge, so registered outputs line up
  // with the state they belong to.
  assign we_n    = accept ? req_we    : we_q;
  assign addr_n  = accept ? req_addr  : addr_q;
  assign wdata_n = accept ? req_wdata : wdata_q;

  always_comb begin
    row_dec = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_dec[i] = (addr_n == AW'(i));
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (addr_bad)    next_state = RESP;
          else if (req_we) next_state = W_SETUP;
          else             next_state = R_PRE;
        end
      end
      W_SETUP: next_state = W_PULSE;
      W_PULSE: if (cnt == '0) next_state = W_HOLD;
      W_HOLD:  next_state = RESP;
      R_PRE:   if (cnt == '0) next_state = R_ACC;
      R_ACC:   if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counter reloads on each state entry and saturates at zero.
  always_comb begin
    cnt_next = cnt;
    if (next_state != state) begin
      case (next_state)
        W_PULSE: cnt_next = CW'(WR_PULSE - 1);
        R_PRE:   cnt_next = CW'(PRE_CYC - 1);
        R_ACC:   cnt_next = CW'(ACC_CYC - 1);
        default: cnt_next = '0;
      endcase
    end else if (cnt != '0) begin
      cnt_next = cnt - 1'b1;
    end
  end

  always_comb begin
    sense_capture   = (state == R_ACC) && (cnt == '0);
    sense_clear     = (next_state == RESP) && (state != RESP) && !sense_capture;
    sense_force_err = (state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_wr    <= '0;
      row_rd    <= '0;
      bl_wr     <= '0;
      blb_wr    <= '0;
      pre_rd    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
    end else begin
      row_wr    <= (next_state == W_PULSE) ? row_dec : '0;
      row_rd    <= (next_state == R_ACC)   ? row_dec : '0;
      pre_rd    <= (next_state == R_PRE);
      rsp_valid <= (next_state == RESP);
      if (next_state == W_SETUP || next_state == W_PULSE || next_state == W_HOLD) begin
        bl_wr  <= wdata_n;
        blb_wr <= ~wdata_n;
      end else begin
        bl_wr  <= '0;
        blb_wr <= '0;
      end
      if (next_state == RESP && state != RESP) rsp_we <= we_n;
    end
  end

  sram_sense_latch #(.COLS(COLS)) u_sense (
    .clk       (clk),
    .rst       (rst),
    .capture   (sense_capture),
    .clear     (sense_clear),
    .force_err (sense_force_err),
    .bl        (bl_rd),
    .blb       (blb_rd),
    .data      (rsp_rdata),
    .err       (rsp_err)
  );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed bench for sram_rw_ctrl: default geometry plus a ROWS=6 instance
// for the out-of-range address bypass.
module tb_sram_rw_ctrl;
  import sram_pkg::*;

  logic clk;
  logic rst;

  // Default-geometry instance
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata, row_wr, row_rd, bl_wr, blb_wr, bl_rd, blb_rd, rsp_rdata;
  logic       pre_rd, rsp_valid, rsp_we, rsp_err;
  state_t     state;

  // ROWS=6 instance
  logic       req_valid6, req_ready6, req_we6;
  logic [2:0] req_addr6;
  logic [7:0] req_wdata6, bl_wr6, blb_wr6, bl_rd6, blb_rd6, rsp_rdata6;
  logic [5:0] row_wr6, row_rd6;
  logic       pre_rd6, rsp_valid6, rsp_we6, rsp_err6;
  state_t     state6;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  sram_rw_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .row_wr(row_wr), .row_rd(row_rd), .bl_wr(bl_wr), .blb_wr(blb_wr),
    .pre_rd(pre_rd), .bl_rd(bl_rd), .blb_rd(blb_rd),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .state(state)
  );

  sram_rw_ctrl #(.ROWS(6)) dut6 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid6), .req_ready(req_ready6), .req_we(req_we6),
    .req_addr(req_addr6), .req_wdata(req_wdata6),
    .row_wr(row_wr6), .row_rd(row_rd6), .bl_wr(bl_wr6), .blb_wr(blb_wr6),
    .pre_rd(pre_rd6), .bl_rd(bl_rd6), .blb_rd(blb_rd6),
    .rsp_valid(rsp_valid6), .rsp_we(rsp_we6), .rsp_rdata(rsp_rdata6),
    .rsp_err(rsp_err6), .state(state6)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word-line exclusivity monitor on both instances
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_wr_onehot", 32'($onehot0(row_wr)), 32'd1);
      check("inv_rd_onehot", 32'($onehot0(row_rd)), 32'd1);
      check("inv_wr_rd_excl", 32'((|row_wr) && (|row_rd)), 32'd0);
      check("inv_pre_rd_excl", 32'(pre_rd && (|row_rd)), 32'd0);
      check("inv6_wr_onehot", 32'($onehot0(row_wr6)), 32'd1);
      check("inv6_rd_onehot", 32'($onehot0(row_rd6)), 32'd1);
      check("inv6_wr_rd_excl", 32'((|row_wr6) && (|row_rd6)), 32'd0);
      check("inv6_pre_rd_excl", 32'(pre_rd6 && (|row_rd6)), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; bl_rd = '0; blb_rd = '0;
    req_valid6 = 0; req_we6 = 0; req_addr6 = '0; req_wdata6 = '0; bl_rd6 = '0; blb_rd6 = '0;

    // Reset state
    tick();
    mon_en = 1;
    tick();
    check("rst_row_wr", 32'(row_wr), 32'h0);
    check("rst_row_rd", 32'(row_rd), 32'h0);
    check("rst_bl_wr", 32'(bl_wr), 32'h0);
    check("rst_blb_wr", 32'(blb_wr), 32'h0);
    check("rst_pre_rd", 32'(pre_rd), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(req_ready), 32'h1);

    // Write addr 3, data A5 (accept edge = t)
    req_valid = 1; req_we = 1; req_addr = 3'd3; req_wdata = 8'hA5;
    tick();
    req_valid = 0;
    check("wr_t1_ready", 32'(req_ready), 32'h0);
    check("wr_t1_bl", 32'(bl_wr), 32'hA5);
    check("wr_t1_blb", 32'(blb_wr), 32'h5A);
    check("wr_t1_row", 32'(row_wr), 32'h00);
    tick();
    check("wr_t2_row", 32'(row_wr), 32'h08);
    check("wr_t2_bl", 32'(bl_wr), 32'hA5);
    tick();
    check("wr_t3_row", 32'(row_wr), 32'h08);
    check("wr_t3_blb", 32'(blb_wr), 32'h5A);
    tick();
    check("wr_t4_row", 32'(row_wr), 32'h00);
    check("wr_t4_bl", 32'(bl_wr), 32'hA5);
    check("wr_t4_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("wr_t5_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_t5_rsp_we", 32'(rsp_we), 32'h1);
    check("wr_t5_rsp_err", 32'(rsp_err), 32'h0);
    check("wr_t5_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("wr_t5_bl", 32'(bl_wr), 32'h0);
    tick();
    check("wr_t6_rsp_valid", 32'(rsp_valid), 32'h0);
    check("wr_t6_ready", 32'(req_ready), 32'h1);
    check("wr_t6_rsp_we_hold", 32'(rsp_we), 32'h1);

    // Clean read addr 3
    bl_rd = 8'hA5; blb_rd = 8'h5A;
    req_valid = 1; req_we = 0; req_addr = 3'd3;
    tick();
    req_valid = 0;
    check("rd_t1_pre", 32'(pre_rd), 32'h1);
    check("rd_t1_row", 32'(row_rd), 32'h00);
    tick();
    check("rd_t2_row", 32'(row_rd), 32'h08);
    check("rd_t2_pre", 32'(pre_rd), 32'h0);
    tick();
    check("rd_t3_row", 32'(row_rd), 32'h08);
    tick();
    check("rd_t4_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_t4_rdata", 32'(rsp_rdata), 32'hA5);
    check("rd_t4_err", 32'(rsp_err), 32'h0);
    check("rd_t4_we", 32'(rsp_we), 32'h0);
    check("rd_t4_row", 32'(row_rd), 32'h00);
    tick();
    check("rd_t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rd_t5_rdata_hold", 32'(rsp_rdata), 32'hA5);

    // Read with equal levels on bit 0
    blb_rd = 8'h5B;
    req_valid = 1; req_addr = 3'd1;
    tick();
    req_valid = 0;
    tick();
    check("rde_t2_row", 32'(row_rd), 32'h02);
    tick();
    tick();
    check("rde_t4_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rde_t4_rdata", 32'(rsp_rdata), 32'hA4);
    check("rde_t4_err", 32'(rsp_err), 32'h1);
    tick();
    check("rde_t5_err_hold", 32'(rsp_err), 32'h1);

    // Two back-to-back reads with req_valid held high
    bl_rd = 8'h0F; blb_rd = 8'hF0;
    req_valid = 1; req_we = 0; req_addr = 3'd2;
    check("b2b_ready_pre", 32'(req_ready), 32'h1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      check("b2b_ready_busy", 32'(req_ready), 32'h0);
      if (k == 2) check("b2b_row", 32'(row_rd), 32'h04);
      if (k == 4) begin
        check("b2b_rsp1_valid", 32'(rsp_valid), 32'h1);
        check("b2b_rsp1_rdata", 32'(rsp_rdata), 32'h0F);
        check("b2b_rsp1_err", 32'(rsp_err), 32'h0);
      end
      if (k < 4) tick();
    end
    tick();
    check("b2b_t5_ready", 32'(req_ready), 32'h1);
    check("b2b_t5_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    req_valid = 0;
    check("b2b_acc2_ready", 32'(req_ready), 32'h0);
    check("b2b_acc2_pre", 32'(pre_rd), 32'h1);
    bl_rd = 8'h3C; blb_rd = 8'hC3;
    tick();
    check("b2b_acc2_row", 32'(row_rd), 32'h04);
    tick();
    tick();
    check("b2b_rsp2_valid", 32'(rsp_valid), 32'h1);
    check("b2b_rsp2_rdata", 32'(rsp_rdata), 32'h3C);
    tick();

    // Reset in the middle of the write pulse
    req_valid = 1; req_we = 1; req_addr = 3'd5; req_wdata = 8'h3C;
    tick();
    req_valid = 0;
    tick();
    check("rw_pulse_row", 32'(row_wr), 32'h20);
    #2 rst = 1'b1;
    #1;
    check("rw_async_row", 32'(row_wr), 32'h0);
    check("rw_async_bl", 32'(bl_wr), 32'h0);
    check("rw_async_blb", 32'(blb_wr), 32'h0);
    check("rw_async_state", 32'(state), 32'(IDLE));
    tick();
    check("rw_held_rsp_valid", 32'(rsp_valid), 32'h0);
    #4 rst = 1'b0;
    tick();
    check("rw_release_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      check("rw_no_rsp", 32'(rsp_valid), 32'h0);
      tick();
    end

    // ROWS=6: valid read at top row, then out-of-range bypasses
    bl_rd6 = 8'hFF; blb_rd6 = 8'h00;
    req_valid6 = 1; req_we6 = 0; req_addr6 = 3'd5;
    tick();
    req_valid6 = 0;
    check("r6_t1_pre", 32'(pre_rd6), 32'h1);
    tick();
    check("r6_t2_row", 32'(row_rd6), 32'h20);
    tick();
    tick();
    check("r6_t4_rsp_valid", 32'(rsp_valid6), 32'h1);
    check("r6_t4_rdata", 32'(rsp_rdata6), 32'hFF);
    tick();

    req_valid6 = 1; req_we6 = 0; req_addr6 = 3'd7;
    tick();
    req_valid6 = 0;
    check("byp7_rsp_valid", 32'(rsp_valid6), 32'h1);
    check("byp7_err", 32'(rsp_err6), 32'h1);
    check("byp7_rdata", 32'(rsp_rdata6), 32'h0);
    check("byp7_row_rd", 32'(row_rd6), 32'h0);
    check("byp7_pre", 32'(pre_rd6), 32'h0);
    tick();
    check("byp7_after_valid", 32'(rsp_valid6), 32'h0);
    check("byp7_after_ready", 32'(req_ready6), 32'h1);
    check("byp7_err_hold", 32'(rsp_err6), 32'h1);

    req_valid6 = 1; req_we6 = 1; req_addr6 = 3'd6; req_wdata6 = 8'h77;
    tick();
    req_valid6 = 0;
    check("byp6_rsp_valid", 32'(rsp_valid6), 32'h1);
    check("byp6_err", 32'(rsp_err6), 32'h1);
    check("byp6_we", 32'(rsp_we6), 32'h1);
    check("byp6_row_wr", 32'(row_wr6), 32'h0);
    check("byp6_bl_wr", 32'(bl_wr6), 32'h0);
    tick();
    tick();

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
